// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId.
// Tracks exception state, raises the timer interrupt and flags pending interrupts.
module cp0_regfile #(
  parameter bit          COUNT_HALF = 1'b1,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o,
  output logic        int_pending_o
);

  localparam logic [4:0] R_BADV = 5'd8;
  localparam logic [4:0] R_CNT  = 5'd9;
  localparam logic [4:0] R_CMP  = 5'd11;
  localparam logic [4:0] R_ST   = 5'd12;
  localparam logic [4:0] R_CA   = 5'd13;
  localparam logic [4:0] R_EPC  = 5'd14;
  localparam logic [4:0] R_PRID = 5'd15;

  localparam logic [31:0] ST_RST  = 32'h0040_0000;
  localparam logic [31:0] ST_MASK = 32'h0000_FF03;
  localparam logic [31:0] CA_MASK = 32'h0000_0300;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic        tog_q, tog_d;
  logic        timer_q, timer_d;

  logic        wr, exc, eret, adx;
  logic [4:0]  code;
  logic [31:0] cause_cur, status_wr, cause_wr;

  always_comb begin
    wr        = we_i && (excepttype_i == 32'd0);
    exc       = excepttype_i != 32'd0;
    eret      = excepttype_i == 32'h0000_000e;
    adx       = (excepttype_i == 32'd4) || (excepttype_i == 32'd5);
    cause_cur = {cause_q[31], timer_q, cause_q[29:0]};
    status_wr = ST_RST | (data_i & ST_MASK);
    cause_wr  = (cause_cur & ~CA_MASK) | (data_i & CA_MASK);
    case (excepttype_i)
      32'h1:   code = 5'd0;
      32'h4:   code = 5'd4;
      32'h5:   code = 5'd5;
      32'h8:   code = 5'd8;
      32'h9:   code = 5'd9;
      32'hc:   code = 5'd12;
      default: code = 5'd10;
    endcase
  end

  always_comb begin
    tog_d     = ~tog_q;
    count_d   = count_q + (COUNT_HALF ? {31'd0, tog_q} : 32'd1);
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    badv_d    = badv_q;
    timer_d   = timer_q | ((compare_q != 32'd0) && (count_q == compare_q));
    cause_d[15:10] = {int_i[5] | timer_q, int_i[4:0]};
    if (wr) begin
      case (waddr_i)
        R_CNT: count_d = data_i;
        R_CMP: begin
          compare_d = data_i;
          timer_d   = 1'b0;
        end
        R_ST:  status_d = status_wr;
        R_CA:  cause_d[9:8] = data_i[9:8];
        R_EPC: epc_d = data_i;
        default: ;
      endcase
    end
    if (eret) begin
      status_d[1] = 1'b0;
    end else if (exc) begin
      // A nested exception keeps the original return point.
      if (!status_q[1]) begin
        epc_d       = in_delayslot_i ? pc_i - 32'd4 : pc_i;
        cause_d[31] = in_delayslot_i;
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = code;
      if (adx) badv_d = bad_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= ST_RST;
      cause_q   <= '0;
      epc_q     <= '0;
      badv_q    <= '0;
      tog_q     <= 1'b0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
      tog_q     <= tog_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    case (raddr_i)
      R_BADV:  data_o = badv_q;
      R_CNT:   data_o = count_q;
      R_CMP:   data_o = compare_q;
      R_ST:    data_o = status_q;
      R_CA:    data_o = cause_cur;
      R_EPC:   data_o = epc_q;
      R_PRID:  data_o = PRID_VAL;
      default: data_o = '0;
    endcase
    if (wr && (waddr_i == raddr_i)) begin
      case (waddr_i)
        R_CNT, R_CMP, R_EPC: data_o = data_i;
        R_ST:    data_o = status_wr;
        R_CA:    data_o = cause_wr;
        default: ;
      endcase
    end
  end

  assign status_o      = status_q;
  assign cause_o       = cause_cur;
  assign epc_o         = epc_q;
  assign timer_int_o   = timer_q;
  assign int_pending_o = status_q[0] & ~status_q[1] &
                         (|(cause_cur[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios plus random traffic
// compared against a behavioural model of the CP0 rules.
module tb_cp0_regfile;

  localparam logic [31:0] PRID = 32'h0000_4220;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i, excepttype_i, pc_i, bad_addr_i;
  logic [5:0]  int_i;
  logic        in_delayslot_i;
  logic [31:0] data_o, status_o, cause_o, epc_o;
  logic        timer_int_o, int_pending_o;

  int total = 0;
  int bad = 0;

  logic [31:0] m_cnt, m_cmp, m_st, m_ca, m_epc, m_bad;
  logic        m_tog, m_tim;
  int          exc_map [int];

  always #5 clk = ~clk;

  cp0_regfile #(.COUNT_HALF(1'b1), .PRID_VAL(PRID)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i),
    .data_i(data_i), .raddr_i(raddr_i), .int_i(int_i),
    .excepttype_i(excepttype_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i),
    .data_o(data_o), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o), .timer_int_o(timer_int_o),
    .int_pending_o(int_pending_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return {m_ca[31], m_tim, m_ca[29:0]};
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] v;
    case (int'(raddr_i))
      8:  v = m_bad;
      9:  v = m_cnt;
      11: v = m_cmp;
      12: v = m_st;
      13: v = m_cause();
      14: v = m_epc;
      15: v = PRID;
      default: v = 0;
    endcase
    if (we_i && excepttype_i == 0 && waddr_i == raddr_i) begin
      case (int'(waddr_i))
        9, 11, 14: v = data_i;
        12: v = 32'h0040_0000 | (data_i & 32'h0000_FF03);
        13: v = (m_cause() & ~32'h300) | (data_i & 32'h300);
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_cmp = 0; m_st = 32'h0040_0000;
    m_ca = 0; m_epc = 0; m_bad = 0; m_tog = 0; m_tim = 0;
  endtask

  task automatic m_step();
    logic [31:0] n_cnt, n_cmp, n_st, n_ca, n_epc, n_bad;
    logic        n_tim;
    int          e;
    if (rst) begin
      m_reset();
      return;
    end
    e = int'(excepttype_i);
    n_cnt = m_cnt + (m_tog ? 32'd1 : 32'd0);
    n_cmp = m_cmp; n_st = m_st; n_ca = m_ca;
    n_epc = m_epc; n_bad = m_bad;
    n_tim = m_tim || (m_cmp != 0 && m_cnt == m_cmp);
    n_ca[15:10] = {int_i[5] | m_tim, int_i[4:0]};
    if (we_i && e == 0) begin
      if (waddr_i == 9) n_cnt = data_i;
      if (waddr_i == 11) begin n_cmp = data_i; n_tim = 0; end
      if (waddr_i == 12) n_st = 32'h0040_0000 | (data_i & 32'hFF03);
      if (waddr_i == 13) n_ca[9:8] = data_i[9:8];
      if (waddr_i == 14) n_epc = data_i;
    end
    if (e == 14) n_st[1] = 0;
    else if (e != 0) begin
      if (!m_st[1]) begin
        n_epc = in_delayslot_i ? pc_i - 4 : pc_i;
        n_ca[31] = in_delayslot_i;
      end
      n_st[1] = 1;
      n_ca[6:2] = exc_map.exists(e) ? 5'(exc_map[e]) : 5'd10;
      if (e == 4 || e == 5) n_bad = bad_addr_i;
    end
    m_cnt = n_cnt; m_cmp = n_cmp; m_st = n_st; m_ca = n_ca;
    m_epc = n_epc; m_bad = n_bad; m_tim = n_tim; m_tog = ~m_tog;
  endtask

  task automatic tick();
    logic [31:0] c;
    @(negedge clk);
    #1;
    if (rst) m_reset();
    c = m_cause();
    chk("status", status_o, m_st);
    chk("cause", cause_o, c);
    chk("epc", epc_o, m_epc);
    chk("timer", {31'd0, timer_int_o}, {31'd0, m_tim});
    chk("pend", {31'd0, int_pending_o},
        {31'd0, m_st[0] & ~m_st[1] & (|(c[15:8] & m_st[15:8]))});
    chk("rdata", data_o, m_read());
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 0; waddr_i = 0; data_i = 0; raddr_i = 0; int_i = 0;
    excepttype_i = 0; pc_i = 0; in_delayslot_i = 0; bad_addr_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    we_i = 1; waddr_i = a; data_i = d;
    tick();
    idle();
  endtask

  initial begin
    int codes[10] = '{1, 4, 5, 8, 9, 10, 12, 14, 2, 31};
    int regs[8] = '{8, 9, 11, 12, 13, 14, 15, 3};
    exc_map = '{1: 0, 4: 4, 5: 5, 8: 8, 9: 9, 10: 10, 12: 12};
    m_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;

    repeat (10) tick();
    raddr_i = 15; #1;
    chk("t1_prid", data_o, PRID);
    raddr_i = 9; #1;
    chk("t1_count", data_o, 32'd5);
    chk("t1_status", status_o, 32'h0040_0000);

    mtc0(11, 32'd20);
    mtc0(9, 32'd18);
    for (int i = 0; i < 20 && !timer_int_o; i++) tick();
    chk("t2_timer", {31'd0, timer_int_o}, 32'd1);
    tick();
    chk("t2_ip7", {31'd0, cause_o[15]}, 32'd1);
    chk("t2_ti", {31'd0, cause_o[30]}, 32'd1);
    mtc0(11, 32'd100);
    chk("t2_clear", {31'd0, timer_int_o}, 32'd0);

    excepttype_i = 8; pc_i = 32'hBFC0_0100; in_delayslot_i = 1;
    tick(); idle(); #1;
    chk("t3_epc", epc_o, 32'hBFC0_00FC);
    chk("t3_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("t3_code", {27'd0, cause_o[6:2]}, 32'd8);
    chk("t3_exl", {31'd0, status_o[1]}, 32'd1);
    excepttype_i = 14;
    tick(); idle(); #1;
    chk("t3_eret", {31'd0, status_o[1]}, 32'd0);
    chk("t3_epc2", epc_o, 32'hBFC0_00FC);

    excepttype_i = 8; pc_i = 32'h100;
    tick(); idle();
    excepttype_i = 4; pc_i = 32'h200; bad_addr_i = 32'h3;
    tick(); idle(); raddr_i = 8; #1;
    chk("t4_epc", epc_o, 32'h100);
    chk("t4_badv", data_o, 32'h3);
    chk("t4_code", {27'd0, cause_o[6:2]}, 32'd4);

    excepttype_i = 14; tick();
    mtc0(12, 32'hFFFF_FFFF);
    chk("t5_st", status_o, 32'h0040_FF03);
    mtc0(12, 32'h0000_0401);
    chk("t5_st2", status_o, 32'h0040_0401);
    we_i = 1; waddr_i = 12; data_i = 32'hFFFF_FFFF; excepttype_i = 9;
    tick(); idle(); #1;
    chk("t5_exc", status_o, 32'h0040_0403);

    excepttype_i = 14; tick(); idle();
    int_i = 6'b000001; tick(); #1;
    chk("t6_pend", {31'd0, int_pending_o}, 32'd1);
    excepttype_i = 1; tick(); idle(); #1;
    chk("t6_exl", {31'd0, status_o[1]}, 32'd1);
    chk("t6_pend0", {31'd0, int_pending_o}, 32'd0);

    we_i = 1; waddr_i = 12; raddr_i = 12; data_i = 0; #1;
    chk("fwd_st", data_o, 32'h0040_0000);
    idle();
    mtc0(9, 32'hFFFF_FFFF);
    repeat (3) tick();

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      we_i = $urandom_range(0, 1);
      waddr_i = 5'(regs[$urandom_range(0, 7)]);
      raddr_i = 5'(regs[$urandom_range(0, 7)]);
      data_i = $urandom_range(0, 1) ? $urandom :
               m_cnt + $urandom_range(0, 6);
      excepttype_i = ($urandom_range(0, 3) == 0) ?
                     codes[$urandom_range(0, 9)] : 0;
      pc_i = $urandom & 32'hFFFF_FFFC;
      in_delayslot_i = $urandom_range(0, 1);
      bad_addr_i = $urandom;
      int_i = 6'($urandom);
      tick();
    end
    rst = 0;
    idle();
    tick();

    mtc0(14, 32'h1234_5678);
    #2 rst = 1; #1;
    chk("arst_epc", epc_o, 32'd0);
    chk("arst_st", status_o, 32'h0040_0000);
    tick();
    rst = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
